// File: rtl/mont_pkg.sv
// Shared constants and FSM state encoding for the Montgomery exponentiation
// sequencer and its bit-scan helper.
package mont_pkg;

    localparam int MONT_WIDTH     = 381;
    localparam int MONT_EXP_WIDTH = 381;
    localparam int MONT_CNT_W     = 9;

    // Sequencer states; plain constants so older code can compare against them.
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] LOAD      = 4'd1;
    localparam logic [3:0] SCAN      = 4'd2;
    localparam logic [3:0] SQR_ISSUE = 4'd3;
    localparam logic [3:0] SQR_WAIT  = 4'd4;
    localparam logic [3:0] MUL_ISSUE = 4'd5;
    localparam logic [3:0] MUL_WAIT  = 4'd6;
    localparam logic [3:0] NEXT      = 4'd7;
    localparam logic [3:0] FIN       = 4'd8;

endpackage

// File: rtl/mont_exp_if.sv
// Handshake/operand bus between the exponentiation sequencer (master) and the
// Montgomery multiplier (slave).
interface mont_exp_if #(
    parameter int WIDTH = 381
);
    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_m;
    logic [WIDTH-1:0] mul_result;
    logic             mul_done;

    modport master (
        output mul_start, mul_a, mul_b, mul_m,
        input  mul_result, mul_done
    );

    modport slave (
        input  mul_start, mul_a, mul_b, mul_m,
        output mul_result, mul_done
    );
endinterface

// File: rtl/mont_exp_bitscan.sv
// Exponent register plus MSB-first bit-index counter for mont_exp.
// load latches a new exponent, init points idx at the top bit, dec steps down.
import mont_pkg::*;

module mont_exp_bitscan #(
    parameter int EXP_WIDTH = MONT_EXP_WIDTH,
    parameter int CNT_W     = MONT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [EXP_WIDTH-1:0] exp_in,
    input  logic                 init,
    input  logic                 dec,
    output logic                 cur_bit,
    output logic                 idx_zero
);

    logic [EXP_WIDTH-1:0] exp_q;
    logic [CNT_W-1:0]     idx_q;

    // Exponent capture and index walk from EXP_WIDTH-1 down to 0.
    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q <= '0;
            idx_q <= '0;
        end else begin
            if (load) begin
                exp_q <= exp_in;
            end
            if (init) begin
                idx_q <= CNT_W'(EXP_WIDTH - 1);
            end else if (dec) begin
                idx_q <= idx_q - CNT_W'(1);
            end
        end
    end

    assign cur_bit  = exp_q[idx_q];
    assign idx_zero = (idx_q == '0);

endmodule

// File: rtl/mont_exp.sv
// Modular exponentiation sequencer: X = base^exp (Montgomery domain) by
// left-to-right square-and-multiply, driving an external Montgomery multiplier.
// Optional build macro MONT_EXP_CT_EN: constant-time mode (every bit runs a
// square and a multiply; the multiply result is kept only when the bit is 1).
import mont_pkg::*;

module mont_exp #(
    parameter int WIDTH     = MONT_WIDTH,
    parameter int EXP_WIDTH = MONT_EXP_WIDTH,
    parameter int CNT_W     = MONT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_base,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_one,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    mont_exp_if.master           mul
);

    logic [3:0]       state_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] one_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             busy_q;

    logic exp_load;
    logic idx_init;
    logic idx_dec;
    logic cur_bit;
    logic idx_zero;

    mont_exp_bitscan #(
        .EXP_WIDTH (EXP_WIDTH),
        .CNT_W     (CNT_W)
    ) u_bitscan (
        .clk      (clk),
        .reset    (reset),
        .load     (exp_load),
        .exp_in   (in_exp),
        .init     (idx_init),
        .dec      (idx_dec),
        .cur_bit  (cur_bit),
        .idx_zero (idx_zero)
    );

    // Bit-scan strobes decoded from the current state.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        exp_load = 1'b0;
        idx_init = 1'b0;
        idx_dec  = 1'b0;
        case (state_q)
            IDLE: exp_load = start;
            LOAD: idx_init = 1'b1;
`ifdef MONT_EXP_CT_EN
            SCAN: idx_dec = 1'b0;
`else
            SCAN: idx_dec = !idx_zero;
`endif
            NEXT: idx_dec = !idx_zero;
            default: ;
        endcase
    end

    // Sequencer: operand capture, accumulator updates, completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            m_q      <= '0;
            one_q    <= '0;
            x_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy drops in the done cycle unless a new run is accepted.
                    busy_q <= start;
                    if (start) begin
                        base_q  <= in_base;
                        m_q     <= in_m;
                        one_q   <= in_one;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    x_q     <= one_q;
                    state_q <= SCAN;
                end
                SCAN: begin
`ifdef MONT_EXP_CT_EN
                    // Constant time: X stays at one, every bit is processed.
                    state_q <= SQR_ISSUE;
`else
                    // Skip leading zeros; the top set bit seeds X with base.
                    if (cur_bit) begin
                        x_q     <= base_q;
                        state_q <= idx_zero ? FIN : SQR_ISSUE;
                    end else if (idx_zero) begin
                        state_q <= FIN;
                    end
`endif
                end
                SQR_ISSUE: state_q <= SQR_WAIT;
                SQR_WAIT: begin
                    if (mul.mul_done) begin
                        x_q <= mul.mul_result;
`ifdef MONT_EXP_CT_EN
                        state_q <= MUL_ISSUE;
`else
                        state_q <= cur_bit ? MUL_ISSUE : NEXT;
`endif
                    end
                end
                MUL_ISSUE: state_q <= MUL_WAIT;
                MUL_WAIT: begin
                    if (mul.mul_done) begin
`ifdef MONT_EXP_CT_EN
                        // Dummy multiply for a zero bit: result is discarded.
                        if (cur_bit) begin
                            x_q <= mul.mul_result;
                        end
`else
                        x_q <= mul.mul_result;
`endif
                        state_q <= NEXT;
                    end
                end
                NEXT: state_q <= idx_zero ? FIN : SQR_ISSUE;
                FIN: begin
                    result_q <= x_q;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operands come straight from registers, so they stay stable through WAIT.
    assign mul.mul_start = (state_q == SQR_ISSUE) || (state_q == MUL_ISSUE);
    assign mul.mul_a     = x_q;
    assign mul.mul_b     = ((state_q == MUL_ISSUE) || (state_q == MUL_WAIT)) ? base_q : x_q;
    assign mul.mul_m     = m_q;

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mont_exp.sv
// Self-checking bench for mont_exp with a mock (a*b) mod m multiplier of
// fixed latency and in_one=1, so Montgomery form reduces to plain arithmetic.
// Define MONT_EXP_CT_EN for both bench and RTL to check constant-time mode.
module tb_mont_exp;
    import mont_pkg::*;

    localparam int W       = 381;
    localparam int EW      = 381;
    localparam int CW      = 9;
    localparam int MUL_LAT = 5;
    localparam int BUDGET  = 20000;
`ifdef MONT_EXP_CT_EN
    localparam int N_RAND  = 2;
`else
    localparam int N_RAND  = 16;
`endif

    typedef logic [W-1:0]   word_t;
    typedef logic [2*W-1:0] wide_t;
    typedef logic [EW-1:0]  expw_t;
    typedef struct {
        word_t res;
        int    muls;
    } exp_t;

    localparam word_t P381 = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    logic  clk = 1'b0;
    logic  reset;
    logic  start;
    word_t in_base, in_m, in_one, result;
    expw_t in_exp;
    logic  done, busy;

    mont_exp_if #(.WIDTH(W)) mul_bus ();

    mont_exp #(.WIDTH(W), .EXP_WIDTH(EW), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_base (in_base),
        .in_exp  (in_exp),
        .in_m    (in_m),
        .in_one  (in_one),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .mul     (mul_bus.master)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic word_t modmul(input word_t a, input word_t b, input word_t m);
        wide_t p;
        p = wide_t'(a) * wide_t'(b);
        p = p % wide_t'(m);
        return p[W-1:0];
    endfunction

    // Right-to-left binary power: independent of the DUT's scan order.
    function automatic word_t ref_pow(input word_t b, input expw_t e, input word_t m, input word_t one);
        word_t r  = one;
        word_t bb = b;
        expw_t ee = e;
        while (ee != '0) begin
            if (ee[0]) r = modmul(r, bb, m);
            bb = modmul(bb, bb, m);
            ee = ee >> 1;
        end
        return r;
    endfunction

    function automatic int ref_muls(input expw_t e);
`ifdef MONT_EXP_CT_EN
        return 2 * EW;
`else
        int top = 0;
        if (e == '0) return 0;
        for (int i = 0; i < EW; i++) if (e[i]) top = i;
        return top + $countones(e) - 1;
`endif
    endfunction

    function automatic word_t rand_word();
        word_t w = '0;
        for (int i = 0; i < 12; i++) w = (w << 32) | word_t'($urandom());
        return w;
    endfunction

    // ---------------- mock multiplier ----------------
    int    mock_cnt;
    word_t mock_p;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mock_cnt           <= 0;
            mock_p             <= '0;
            mul_bus.mul_done   <= 1'b0;
            mul_bus.mul_result <= '0;
        end else begin
            mul_bus.mul_done <= 1'b0;
            if (mock_cnt == 1) begin
                mul_bus.mul_done   <= 1'b1;
                mul_bus.mul_result <= mock_p;
            end
            if (mock_cnt != 0) mock_cnt <= mock_cnt - 1;
            if (mul_bus.mul_start) begin
                mock_cnt <= MUL_LAT;
                mock_p   <= modmul(mul_bus.mul_a, mul_bus.mul_b, mul_bus.mul_m);
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   mul_cnt = 0;
    int   last_muls = 0;
    int   done_cycle = 0;
    int   done_events = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (!reset) begin
            if (mul_bus.mul_start) mul_cnt++;
            if (done) begin
                exp_t e;
                done_cycle = cycle;
                done_events++;
                last_muls = mul_cnt;
                check("busy_at_done", word_t'(busy), word_t'(1));
                check("sb_nonempty", word_t'(sb_q.size() != 0), word_t'(1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("result", result, e.res);
                    check("mul_count", word_t'(mul_cnt), word_t'(e.muls));
                end
                mul_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sb_q.delete();
        mul_cnt = 0;
        reset = 1'b0;
    endtask

    task automatic run(input word_t b, input expw_t e, input word_t m, output int lat);
        int n0, t0;
        bit seen;
        @(negedge clk);
        in_base = b;
        in_exp  = e;
        in_m    = m;
        start   = 1'b1;
        sb_q.push_back('{res: ref_pow(b, e, m, in_one), muls: ref_muls(e)});
        mul_cnt = 0;
        n0 = done_events;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cycle;
        check("busy_after_start", word_t'(busy), word_t'(1));
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            #1;
            if (done_events != n0) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", word_t'(seen), word_t'(1));
        if (!seen) begin
            lat = -1;
            do_reset();
        end else begin
            lat = done_cycle - t0;
            @(negedge clk);
            #1;
            check("done_one_cycle", word_t'(done), word_t'(0));
            check("busy_cleared", word_t'(busy), word_t'(0));
        end
    endtask

    initial begin
        int lat, lat5, lat0;
        bit seen;
        word_t rm, rb;
        expw_t re;

        reset   = 1'b1;
        start   = 1'b0;
        in_base = '0;
        in_exp  = '0;
        in_m    = '0;
        in_one  = word_t'(1);
        #12;
        check("rst_result", result, '0);
        check("rst_done", word_t'(done), '0);
        check("rst_busy", word_t'(busy), '0);
        check("rst_mul_start", word_t'(mul_bus.mul_start), '0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        run(word_t'(3), expw_t'(5), word_t'(13), lat5);
        check("b3e5_value", result, word_t'(9));
`ifdef MONT_EXP_CT_EN
        check("b3e5_muls", word_t'(last_muls), word_t'(2 * EW));
`else
        check("b3e5_muls", word_t'(last_muls), word_t'(3));
`endif
        run(word_t'(7), expw_t'(0), word_t'(13), lat0);
        check("e0_value", result, word_t'(1));
`ifdef MONT_EXP_CT_EN
        check("ct_latency_equal", word_t'(lat0), word_t'(lat5));
`else
        // LOAD + one SCAN per bit + FIN, with done registered out of FIN.
        check("e0_latency", word_t'(lat0), word_t'(EW + 2));
        check("e0_muls", word_t'(last_muls), word_t'(0));
`endif
        run(word_t'(7), expw_t'(1), word_t'(13), lat);
        check("e1_value", result, word_t'(7));
        run(word_t'(2), expw_t'(12), word_t'(13), lat);
        check("fermat13", result, word_t'(1));

        // Start during SQR_WAIT is ignored; reset during MUL_WAIT clears all.
        @(negedge clk);
        in_base = word_t'(3);
        in_exp  = expw_t'(5);
        in_m    = word_t'(13);
        start   = 1'b1;
        mul_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            #1;
            if (mul_cnt >= 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("first_sqr_seen", word_t'(seen), word_t'(1));
        @(negedge clk);
        in_base = word_t'(5);
        in_exp  = expw_t'(0);
        in_m    = word_t'(7);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifndef MONT_EXP_CT_EN
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (mul_cnt >= 3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("third_mul_seen", word_t'(seen), word_t'(1));
        // 3^2=9, 9^2=81=3 mod 13; now multiply X=3 by base=3 under m=13.
        check("ign_mul_a", mul_bus.mul_a, word_t'(3));
        check("ign_mul_b", mul_bus.mul_b, word_t'(3));
        check("ign_mul_m", mul_bus.mul_m, word_t'(13));
        @(negedge clk);
`else
        check("ign_mul_m", mul_bus.mul_m, word_t'(13));
`endif
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", word_t'(busy), '0);
        check("mid_rst_done", word_t'(done), '0);
        check("mid_rst_mul_start", word_t'(mul_bus.mul_start), '0);
        check("mid_rst_result", result, '0);
        check("mid_rst_state", word_t'(dut.state_q), word_t'(IDLE));
        sb_q.delete();
        mul_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        run(word_t'(3), expw_t'(5), word_t'(13), lat);
        check("post_rst_value", result, word_t'(9));

        // Randomized small-modulus runs.
        for (int n = 0; n < N_RAND; n++) begin
            rm = word_t'($urandom_range(65535, 3)) | word_t'(1);
            rb = word_t'($urandom()) % rm;
            re = expw_t'($urandom() >> $urandom_range(31, 8));
            run(rb, re, rm, lat);
        end

        // Random 381-bit modulus with a 32-bit exponent.
        rm = rand_word() | word_t'(1);
        rm[W-1] = 1'b1;
        rb = rand_word() % rm;
        run(rb, expw_t'($urandom()), rm, lat);

        // Field inversion over BLS12-381 p: 5^(p-2) * 5 == 1 mod p.
        run(word_t'(5), expw_t'(P381 - word_t'(2)), P381, lat);
        check("p381_inverse", modmul(result, word_t'(5), P381), word_t'(1));

        check("sb_drained", word_t'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
